// File: rtl/id_stage.sv
// ----------------------------------------------------------------------------
// id_stage
//
// RV32I instruction-decode stage. Takes one instruction per cycle from fetch
// over a valid/ready handshake. It drives the register_file read indices
// combinationally from the presented instruction and captures the returned
// operands into the ID/EX register, together with the decoded control fields
// and the sign-extended immediate. A per-register busy scoreboard stalls
// read-after-write hazards until writeback retires the producing instruction.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   i_if_valid/o_if_ready fetch handshake; i_if_instr / i_if_pc its payload
//   o_r_reg_num_1/2      register_file read indices (rs1 / rs2 fields)
//   i_r_reg_1/2          register_file read data (combinational return)
//   i_wb_valid, i_wb_rd  writeback retires a write to register i_wb_rd
//   i_flush              squash the stage (taken branch or jump)
//   o_ex_valid/i_ex_ready ID/EX handshake toward execute
//   o_ex_*               ID/EX register contents
// ----------------------------------------------------------------------------
module id_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            i_if_valid,
    output logic            o_if_ready,
    input  logic [31:0]     i_if_instr,
    input  logic [XLEN-1:0] i_if_pc,

    output logic [4:0]      o_r_reg_num_1,
    output logic [4:0]      o_r_reg_num_2,
    input  logic [XLEN-1:0] i_r_reg_1,
    input  logic [XLEN-1:0] i_r_reg_2,

    input  logic            i_wb_valid,
    input  logic [4:0]      i_wb_rd,

    input  logic            i_flush,

    output logic            o_ex_valid,
    input  logic            i_ex_ready,
    output logic [XLEN-1:0] o_ex_pc,
    output logic [XLEN-1:0] o_ex_rs1_val,
    output logic [XLEN-1:0] o_ex_rs2_val,
    output logic [XLEN-1:0] o_ex_imm,
    output logic [4:0]      o_ex_rd,
    output logic [6:0]      o_ex_opcode,
    output logic [2:0]      o_ex_funct3,
    output logic            o_ex_funct7b5,
    output logic            o_ex_reg_write,
    output logic            o_ex_illegal
);

    // RV32I base opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Immediate formats
    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    logic [6:0]       opcode;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;

    logic             uses_rs1;
    logic             uses_rs2;
    logic             writes_rd_op;
    logic             writes_rd;
    logic             illegal;
    logic [2:0]       imm_sel;
    logic [31:0]      imm32;

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;
    logic             hazard;
    logic             accept;

    assign opcode = i_if_instr[6:0];
    assign rd     = i_if_instr[11:7];
    assign rs1    = i_if_instr[19:15];
    assign rs2    = i_if_instr[24:20];

    assign o_r_reg_num_1 = rs1;
    assign o_r_reg_num_2 = rs2;

    // Per-opcode operand usage, destination write and immediate format.
    // Unknown opcodes use no operands, so they can never stall on the
    // scoreboard, and they never claim a destination.
    always_comb begin
        uses_rs1     = 1'b0;
        uses_rs2     = 1'b0;
        writes_rd_op = 1'b0;
        illegal      = 1'b0;
        imm_sel      = IMM_NONE;
        case (opcode)
            OPC_LUI: begin
                writes_rd_op = 1'b1;
                imm_sel      = IMM_U;
            end
            OPC_AUIPC: begin
                writes_rd_op = 1'b1;
                imm_sel      = IMM_U;
            end
            OPC_JAL: begin
                writes_rd_op = 1'b1;
                imm_sel      = IMM_J;
            end
            OPC_JALR: begin
                uses_rs1     = 1'b1;
                writes_rd_op = 1'b1;
                imm_sel      = IMM_I;
            end
            OPC_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                imm_sel  = IMM_B;
            end
            OPC_LOAD: begin
                uses_rs1     = 1'b1;
                writes_rd_op = 1'b1;
                imm_sel      = IMM_I;
            end
            OPC_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                imm_sel  = IMM_S;
            end
            OPC_OPIMM: begin
                uses_rs1     = 1'b1;
                writes_rd_op = 1'b1;
                imm_sel      = IMM_I;
            end
            OPC_OP: begin
                uses_rs1     = 1'b1;
                uses_rs2     = 1'b1;
                writes_rd_op = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    // Writes to x0 are architecturally discarded, so they never reach the
    // scoreboard or execute.
    assign writes_rd = writes_rd_op & (rd != 5'd0);

    // Immediate assembly; every format sign-extends from instr[31].
    always_comb begin
        imm32 = 32'd0;
        case (imm_sel)
            IMM_I: imm32 = {{20{i_if_instr[31]}}, i_if_instr[31:20]};
            IMM_S: imm32 = {{20{i_if_instr[31]}}, i_if_instr[31:25],
                            i_if_instr[11:7]};
            IMM_B: imm32 = {{19{i_if_instr[31]}}, i_if_instr[31], i_if_instr[7],
                            i_if_instr[30:25], i_if_instr[11:8], 1'b0};
            IMM_U: imm32 = {i_if_instr[31:12], 12'd0};
            IMM_J: imm32 = {{11{i_if_instr[31]}}, i_if_instr[31],
                            i_if_instr[19:12], i_if_instr[20],
                            i_if_instr[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
    end

    // Hazard uses only the registered busy bits: a writeback retiring in the
    // same cycle releases the stall one cycle later, keeping the ready path
    // free of the writeback bus.
    assign hazard = (uses_rs1 & busy[rs1]) | (uses_rs2 & busy[rs2]);

    assign o_if_ready = ~rst & ~i_flush & ~hazard & (~o_ex_valid | i_ex_ready);
    assign accept     = i_if_valid & o_if_ready;

    // Scoreboard next state. Ordering matters: clears first, then the set
    // from a newly accepted producer, so a set wins over a same-cycle clear
    // of the same register. A flushed ID/EX entry gives back the busy bit it
    // claimed; older instructions beyond ID keep theirs. x0 is pinned clear.
    always_comb begin
        busy_next = busy;
        if (i_wb_valid) begin
            busy_next[i_wb_rd] = 1'b0;
        end
        if (i_flush && o_ex_valid && o_ex_reg_write) begin
            busy_next[o_ex_rd] = 1'b0;
        end
        if (accept && writes_rd) begin
            busy_next[rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // ID/EX register. Fields load only on accept, so they hold stable while
    // execute back-pressures. Valid drops on flush or when execute drains the
    // entry without a replacement arriving.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy           <= '0;
            o_ex_valid     <= 1'b0;
            o_ex_pc        <= '0;
            o_ex_rs1_val   <= '0;
            o_ex_rs2_val   <= '0;
            o_ex_imm       <= '0;
            o_ex_rd        <= 5'd0;
            o_ex_opcode    <= 7'd0;
            o_ex_funct3    <= 3'd0;
            o_ex_funct7b5  <= 1'b0;
            o_ex_reg_write <= 1'b0;
            o_ex_illegal   <= 1'b0;
        end else begin
            busy <= busy_next;
            if (accept) begin
                o_ex_valid     <= 1'b1;
                o_ex_pc        <= i_if_pc;
                o_ex_rs1_val   <= i_r_reg_1;
                o_ex_rs2_val   <= i_r_reg_2;
                o_ex_imm       <= XLEN'($signed(imm32));
                o_ex_rd        <= rd;
                o_ex_opcode    <= opcode;
                o_ex_funct3    <= i_if_instr[14:12];
                o_ex_funct7b5  <= i_if_instr[30];
                o_ex_reg_write <= writes_rd & ~illegal;
                o_ex_illegal   <= illegal;
            end else if (i_flush || i_ex_ready) begin
                o_ex_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- RV32I instruction-decode stage. Sits between fetch and execute, directly upstream of register_file.
- Accepts one instruction per cycle from fetch over a valid/ready handshake.
- Drives the register_file read ports and captures the operands into an ID/EX pipeline register together with decoded control and immediate.
- Holds a per-register busy scoreboard to stall read-after-write hazards until writeback retires the producer.

Parameters:
- XLEN, 32, data/PC width
- NREGS, 32, architectural register count; scoreboard size; x0 is never busy

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- i_if_valid  in  1  fetch holds a valid instruction
- o_if_ready  out  1  stage accepts the instruction this cycle
- i_if_instr  in  32  instruction word
- i_if_pc  in  XLEN  instruction PC
- o_r_reg_num_1  out  5  register_file read port 1 index = i_if_instr[19:15], combinational
- o_r_reg_num_2  out  5  register_file read port 2 index = i_if_instr[24:20], combinational
- i_r_reg_1  in  XLEN  register_file read data 1, combinational return
- i_r_reg_2  in  XLEN  register_file read data 2, combinational return
- i_wb_valid  in  1  writeback retires a register write this cycle
- i_wb_rd  in  5  destination register being retired
- i_flush  in  1  squash the stage (taken branch or jump)
- o_ex_valid  out  1  ID/EX register holds a valid instruction
- i_ex_ready  in  1  execute consumes the ID/EX register this cycle
- o_ex_pc  out  XLEN  PC
- o_ex_rs1_val  out  XLEN  captured i_r_reg_1
- o_ex_rs2_val  out  XLEN  captured i_r_reg_2
- o_ex_imm  out  XLEN  sign-extended immediate
- o_ex_rd  out  5  destination register
- o_ex_opcode  out  7  instr[6:0]
- o_ex_funct3  out  3  instr[14:12]
- o_ex_funct7b5  out  1  instr[30]
- o_ex_reg_write  out  1  instruction writes rd (rd != 0)
- o_ex_illegal  out  1  unsupported opcode

Behaviour:
- Reset: all o_ex_* = 0, o_ex_valid = 0, scoreboard cleared. While rst = 1, o_if_ready = 0.
- Supported opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011.
- Any other opcode: o_ex_illegal = 1, o_ex_reg_write = 0, operands not used.
- uses_rs1: JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
- uses_rs2: BRANCH, STORE, OP.
- writes_rd: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, and only when rd != 0.
- Immediate, all sign-extended from instr[31]:
  - I: JALR, LOAD, OP-IMM
  - S: STORE
  - B: BRANCH, bit 0 = 0
  - U: LUI, AUIPC, instr[31:12] << 12
  - J: JAL, bit 0 = 0
  - Otherwise 0.
- hazard = (uses_rs1 & busy[rs1]) | (uses_rs2 & busy[rs2]). Uses the registered busy bits only; a same-cycle i_wb_valid does not clear the stall. x0 is never busy.
- o_if_ready = ~rst & ~i_flush & ~hazard & (~o_ex_valid | i_ex_ready).
- accept = i_if_valid & o_if_ready. On accept, the ID/EX register loads the decoded fields and i_r_reg_1/2. Latency is 1 cycle.
- Output hold: if o_ex_valid & ~i_ex_ready, every o_ex_* holds stable.
- Output drain: if i_ex_ready and no accept, o_ex_valid falls to 0.
- Scoreboard set: on accept with writes_rd, busy[rd] <= 1.
- Scoreboard clear: on i_wb_valid, busy[i_wb_rd] <= 0.
- Same register set and cleared in one cycle: set wins.
- Flush: o_ex_valid <= 0 next cycle and no accept this cycle.
  - If the squashed ID/EX entry had o_ex_reg_write = 1, busy[o_ex_rd] <= 0, unless i_wb_valid for that rd coincides, in which case the bit is cleared anyway.
  - Instructions already past ID keep their busy bits.
- Flush while stalled: the stall is dropped. Fetch re-presents after the flush.
- Reset mid-stream: all state clears in the next cycle, including the scoreboard.

Test Plan:
- After reset, present 0x00500093 (addi x1,x0,5) at pc 0x100 with i_ex_ready=1 -> next cycle o_ex_valid=1, imm=0x5, rd=1, reg_write=1, pc=0x100; busy[1]=1.
- Then present 0x00108133 (add x2,x1,x1) -> o_if_ready=0 while busy[1]=1. Pulse i_wb_valid with i_wb_rd=1 -> ready rises the following cycle; o_ex_rs1_val = o_ex_rs2_val = the register_file value.
- Present 0xFE20AE23 (sw x2,-4(x1)) with no busy registers -> imm=0xFFFFFFFC, reg_write=0. Present 0xFE000CE3 (beq x0,x0,-8) -> imm=0xFFFFFFF8.
- Present 0x123452B7 (lui x5,0x12345) with i_ex_ready=0 for 3 cycles -> o_ex_* held with imm=0x12345000, o_if_ready=0; drains when i_ex_ready=1.
- ID/EX holds addi x3 (busy[3]=1); assert i_flush -> o_ex_valid=0 next cycle, busy[3]=0, no instruction accepted during the flush cycle.
- Present 0x0000000B (custom opcode) -> o_ex_illegal=1, reg_write=0, no scoreboard change. Assert rst mid-stall -> all outputs 0 and scoreboard clear.
